split_target_mem: RTL and testbench
===================================

# split_target_mem

Byte-addressed memory target that attaches to the split-target (target 3) side of the serial bus and consumes the parallel address/data produced by the split target port. Writes complete in place with an ack. Reads are answered with a split ack, the bus is released, and after a programmable latency the block requests the bus back, returns the byte and acks. It is the slow-memory model and reference implementation that exercises the bus's split path.

## Interface
- ADDR_W, 11: local address bits; memory depth 2^ADDR_W bytes.
- SPLIT_LATENCY, 8: cycles from split_ack to req assertion; legal range 1..255.
- SPLIT_EN, 1: 1 = reads use the split path; 0 = reads answered directly without split.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- addr_in  in  16  address from port; only [ADDR_W-1:0] used, upper bits ignored.
- addr_in_valid  in  1  one-cycle strobe, addr_in and rw valid.
- data_in  in  8  write data.
- data_in_valid  in  1  one-cycle strobe, data_in valid.
- rw  in  1  1 = write, 0 = read; sampled with addr_in_valid.
- grant  in  1  bus grant for the split response.
- ready  out  1  high only in IDLE.
- ack  out  1  one-cycle transaction-complete pulse.
- split_ack  out  1  one-cycle pulse: read accepted, bus released.
- req  out  1  bus request for the split response.
- data_out  out  8  read data.
- data_out_valid  out  1  one-cycle pulse, data_out valid.

## Operation
- States: IDLE, WR_DATA, RD_DIRECT, SPLIT_WAIT, REQ, RESP.
- IDLE: ready=1. On addr_in_valid, latch addr_in[ADDR_W-1:0] and rw.
  - rw=1: go to WR_DATA.
  - rw=0 and SPLIT_EN=1: go to SPLIT_WAIT, load the counter with SPLIT_LATENCY, register split_ack=1 for that first SPLIT_WAIT cycle.
  - rw=0 and SPLIT_EN=0: go to RD_DIRECT.
- WR_DATA: on data_in_valid, write mem[addr] with data_in, pulse ack the next cycle, return to IDLE. No timeout; stays until data arrives.
- RD_DIRECT: read mem[addr] into the rdata register. Next cycle go to RESP.
- SPLIT_WAIT: read mem[addr] into the rdata register on entry. Decrement the counter each cycle. When the counter reaches 1, go to REQ.
- REQ: req=1, held until grant is sampled high. No timeout. Then go to RESP.
- RESP: data_out=rdata, data_out_valid=1, ack=1, req=0 for one cycle, then IDLE.
- The counter is 8 bits, unsigned, with no wrap. SPLIT_LATENCY=0 is illegal; the implementation flags it with an elaboration-time assertion.
- Stimulus ignored while ready=0:
  - addr_in_valid: ignored, no state change.
  - data_in_valid outside WR_DATA: ignored.
  - grant outside REQ: ignored.
- addr_in_valid and data_in_valid in the same IDLE cycle: only the address is taken. The data strobe is dropped, and the write waits for the next data_in_valid.
- Memory is not reset. Contents after rst_n are undefined.

## Timing
- Reset values: ready=1, ack=0, split_ack=0, req=0, data_out=8'h00, data_out_valid=0, state=IDLE, counter=0.
- Reset mid-operation (any state): all outputs go to their reset values immediately (asynchronous). A pending write is dropped; a pending split response is abandoned.
- All outputs are registered.
- Write: data_in_valid at cycle D -> ack at D+1; ready returns at D+2.
- Direct read (SPLIT_EN=0): addr_in_valid at T -> data_out_valid and ack at T+2.
- Split read: addr_in_valid at T -> split_ack at T+1 -> req rises at T+1+SPLIT_LATENCY.
- Response: grant sampled high at G -> data_out_valid and ack at G+1, req=0 at G+1.
- ready is low from T+1 until the cycle after ack.
- ack and split_ack are never high in the same cycle.

## Test plan
- Write then direct read (SPLIT_EN=0): write 8'hA5 to 16'h0123 -> ack 1 cycle after data_in_valid; read 16'h0123 -> data_out=8'hA5 with data_out_valid and ack at T+2; split_ack never asserted.
- Split read, immediate grant (SPLIT_LATENCY=8): preload 16'h0040=8'h3C; read -> split_ack at T+1, req at T+9; grant at T+9 -> data_out=8'h3C, ack at T+10, req low at T+10.
- Delayed grant: hold grant low 20 cycles after req -> req stays high, no ack, ready=0; grant pulse -> response exactly 1 cycle later.
- Busy rejection: during SPLIT_WAIT issue addr_in_valid with rw=1 and data_in_valid with 8'hFF to 16'h0040 -> ignored; mem[16'h0040] still 8'h3C on a later read.
- Address truncation: write 8'h11 to 16'hF801 (ADDR_W=11) -> reading 16'h0001 returns 8'h11.
- Reset in REQ: assert rst_n=0 while req=1 -> req, ack, data_out_valid drop immediately, ready=1; a new read after reset completes normally.

Source files
------------

// File: rtl/split_target_mem_if.sv
// ---------------------------------------------------------------------------
// split_target_mem_if
//
// Bundles the split-target port signals between the bus side (master) and
// the slow-memory target (slave).
//
// Signals (master drives / slave drives):
//   addr_in[15:0], addr_in_valid, rw   address phase strobe from the port
//   data_in[7:0], data_in_valid        write data strobe from the port
//   grant                              bus grant for the split response
//   ready                              target idle and accepting an address
//   ack                                one-cycle transaction-complete pulse
//   split_ack                          one-cycle "read accepted, bus released"
//   req                                bus request for the split response
//   data_out[7:0], data_out_valid      read data and its one-cycle strobe
// ---------------------------------------------------------------------------
interface split_target_mem_if;
    logic [15:0] addr_in;
    logic        addr_in_valid;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        rw;
    logic        grant;
    logic        ready;
    logic        ack;
    logic        split_ack;
    logic        req;
    logic [7:0]  data_out;
    logic        data_out_valid;

    modport master (
        output addr_in, addr_in_valid, data_in, data_in_valid, rw, grant,
        input  ready, ack, split_ack, req, data_out, data_out_valid
    );

    modport slave (
        input  addr_in, addr_in_valid, data_in, data_in_valid, rw, grant,
        output ready, ack, split_ack, req, data_out, data_out_valid
    );
endinterface

// File: rtl/split_target_mem.sv
// ---------------------------------------------------------------------------
// split_target_mem
//
// Byte-addressed slow-memory target for the split side of the serial bus.
// Writes complete in place with an ack. Reads are either answered directly
// (SPLIT_EN=0) or with a split_ack, after which the bus is released and,
// SPLIT_LATENCY cycles later, the target requests the bus back, returns the
// byte and acks.
//
// Parameters:
//   ADDR_W        local address bits, memory depth 2**ADDR_W bytes
//   SPLIT_LATENCY cycles from split_ack to req (1..255)
//   SPLIT_EN      1 = reads use the split path, 0 = direct reads
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    split_target_mem_if.slave (address/data/handshake bundle)
//
// Memory contents are not reset.
// ---------------------------------------------------------------------------
module split_target_mem #(
    parameter int ADDR_W        = 11,
    parameter int SPLIT_LATENCY = 8,
    parameter bit SPLIT_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    split_target_mem_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_DIRECT,
        SPLIT_WAIT,
        REQ,
        RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        count;
    logic [7:0]        rdata;
    logic [7:0]        mem [2**ADDR_W];

    // Address bits above ADDR_W are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr_in[15:ADDR_W];

    generate
        if (SPLIT_LATENCY < 1 || SPLIT_LATENCY > 255) begin : g_bad_latency
            $error("split_target_mem: SPLIT_LATENCY must be in 1..255");
        end
    endgenerate

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (state == WR_DATA && bus.data_in_valid) begin
            mem[addr_q] <= bus.data_in;
        end
    end

    // Control FSM. After a write ack the FSM sits in IDLE with ready low for
    // one cycle, so ready only reappears the cycle after ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            addr_q             <= '0;
            count              <= '0;
            rdata              <= '0;
            bus.ready          <= 1'b1;
            bus.ack            <= 1'b0;
            bus.split_ack      <= 1'b0;
            bus.req            <= 1'b0;
            bus.data_out       <= 8'h00;
            bus.data_out_valid <= 1'b0;
        end else begin
            bus.ack            <= 1'b0;
            bus.split_ack      <= 1'b0;
            bus.data_out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.ready) begin
                        bus.ready <= 1'b1;
                    end else if (bus.addr_in_valid) begin
                        addr_q    <= bus.addr_in[ADDR_W-1:0];
                        bus.ready <= 1'b0;
                        if (bus.rw) begin
                            state <= WR_DATA;
                        end else if (SPLIT_EN) begin
                            state         <= SPLIT_WAIT;
                            count         <= 8'(SPLIT_LATENCY);
                            bus.split_ack <= 1'b1;
                        end else begin
                            state <= RD_DIRECT;
                        end
                    end
                end
                WR_DATA: begin
                    if (bus.data_in_valid) begin
                        bus.ack <= 1'b1;
                        state   <= IDLE;
                    end
                end
                RD_DIRECT: begin
                    rdata              <= mem[addr_q];
                    bus.data_out       <= mem[addr_q];
                    bus.data_out_valid <= 1'b1;
                    bus.ack            <= 1'b1;
                    state              <= RESP;
                end
                SPLIT_WAIT: begin
                    // Memory cannot change while busy, so re-reading each
                    // cycle captures the same byte as reading on entry.
                    rdata <= mem[addr_q];
                    if (count != 8'd0) begin
                        count <= count - 8'd1;
                    end
                    if (count <= 8'd1) begin
                        bus.req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.grant) begin
                        bus.req            <= 1'b0;
                        bus.data_out       <= rdata;
                        bus.data_out_valid <= 1'b1;
                        bus.ack            <= 1'b1;
                        state              <= RESP;
                    end
                end
                RESP: begin
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_split_target_mem.sv
// ---------------------------------------------------------------------------
// tb_split_target_mem
//
// Drives two split_target_mem instances: u_dir (SPLIT_EN=0) and u_spl
// (SPLIT_EN=1, SPLIT_LATENCY=8). Read expectations are queued when a read is
// issued and popped by a monitor whenever data_out_valid is seen. Handshake
// timing is checked from the stimulus side as a status vector
// {ready, ack, split_ack, req, data_out_valid}.
// ---------------------------------------------------------------------------
module tb_split_target_mem;

    logic clk;
    logic rst_n;

    split_target_mem_if dir_if ();
    split_target_mem_if spl_if ();

    split_target_mem #(.ADDR_W(11), .SPLIT_LATENCY(8), .SPLIT_EN(1'b0)) u_dir (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dir_if)
    );

    split_target_mem #(.ADDR_W(11), .SPLIT_LATENCY(8), .SPLIT_EN(1'b1)) u_spl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (spl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] dir_q[$];
    logic [7:0] spl_q[$];
    logic [7:0] exp_dir;
    logic [7:0] exp_spl;

    // Status bit positions: {ready, ack, split_ack, req, data_out_valid}
    localparam logic [4:0] S_IDLE  = 5'b10000;
    localparam logic [4:0] S_BUSY  = 5'b00000;
    localparam logic [4:0] S_ACK   = 5'b01000;
    localparam logic [4:0] S_SPLIT = 5'b00100;
    localparam logic [4:0] S_REQ   = 5'b00010;
    localparam logic [4:0] S_RESP  = 5'b01001;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic logic [4:0] status(input bit s);
        if (s) return {spl_if.ready, spl_if.ack, spl_if.split_ack, spl_if.req, spl_if.data_out_valid};
        return {dir_if.ready, dir_if.ack, dir_if.split_ack, dir_if.req, dir_if.data_out_valid};
    endfunction

    task automatic applyStimulus(input bit s, input logic [15:0] a, input logic av,
                                 input logic [7:0] d, input logic dv,
                                 input logic w, input logic g);
        if (s) begin
            spl_if.addr_in = a; spl_if.addr_in_valid = av; spl_if.data_in = d;
            spl_if.data_in_valid = dv; spl_if.rw = w; spl_if.grant = g;
        end else begin
            dir_if.addr_in = a; dir_if.addr_in_valid = av; dir_if.data_in = d;
            dir_if.data_in_valid = dv; dir_if.rw = w; dir_if.grant = g;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address phase at cycle T, data at D = T+1; ack at D+1, ready at D+2.
    task automatic writeOp(input bit s, input logic [15:0] a, input logic [7:0] d);
        checkOutput("wr_ready_idle", 16'(status(s)), 16'(S_IDLE));
        applyStimulus(s, a, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(s, 16'h0, 1'b0, d, 1'b1, 1'b0, 1'b0);
        checkOutput("wr_busy", 16'(status(s)), 16'(S_BUSY));
        tick();
        applyStimulus(s, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("wr_ack_D+1", 16'(status(s)), 16'(S_ACK));
        tick();
        checkOutput("wr_ready_D+2", 16'(status(s)), 16'(S_IDLE));
    endtask

    // Direct read: data_out_valid and ack at T+2, ready at T+3.
    task automatic directRead(input logic [15:0] a, input logic [7:0] e);
        checkOutput("drd_ready_idle", 16'(status(0)), 16'(S_IDLE));
        dir_q.push_back(e);
        applyStimulus(0, a, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("drd_T+1", 16'(status(0)), 16'(S_BUSY));
        tick();
        checkOutput("drd_T+2", 16'(status(0)), 16'(S_RESP));
        tick();
        checkOutput("drd_T+3", 16'(status(0)), 16'(S_IDLE));
    endtask

    // Split read: split_ack at T+1, req at T+9, response one cycle after grant.
    task automatic splitRead(input logic [15:0] a, input logic [7:0] e, input int gdelay,
                             input bit busy, input bit rst_in_req);
        int cyc;
        checkOutput("srd_ready_idle", 16'(status(1)), 16'(S_IDLE));
        spl_q.push_back(e);
        applyStimulus(1, a, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("srd_split_ack_T+1", 16'(status(1)), 16'(S_SPLIT));
        tick();
        checkOutput("srd_T+2", 16'(status(1)), 16'(S_BUSY));
        cyc = 2;
        if (busy) begin
            applyStimulus(1, 16'h0040, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
            tick();
            applyStimulus(1, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            cyc = 3;
        end
        while (cyc < 8) begin
            tick();
            cyc++;
        end
        checkOutput("srd_no_req_T+8", 16'(status(1)), 16'(S_BUSY));
        tick();
        checkOutput("srd_req_T+9", 16'(status(1)), 16'(S_REQ));
        if (rst_in_req) begin
            rst_n = 1'b0;
            #1;
            checkOutput("rst_async_spl", 16'(status(1)), 16'(S_IDLE));
            checkOutput("rst_data_out", 16'(spl_if.data_out), 16'h0000);
            void'(spl_q.pop_back());
            tick();
            rst_n = 1'b1;
            tick();
            return;
        end
        for (int i = 0; i < gdelay; i++) begin
            tick();
            checkOutput("srd_hold_req", 16'(status(1)), 16'(S_REQ));
        end
        applyStimulus(1, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("srd_resp_G+1", 16'(status(1)), 16'(S_RESP));
        tick();
        checkOutput("srd_ready_after", 16'(status(1)), 16'(S_IDLE));
    endtask

    // Scoreboard monitor: pops an expectation on every read response.
    always @(negedge clk) begin
        if (dir_if.data_out_valid) begin
            if (dir_q.size() == 0) begin
                checkOutput("dir_unexpected_resp", 16'(dir_if.data_out_valid), 16'h0);
            end else begin
                exp_dir = dir_q.pop_front();
                checkOutput("dir_rdata", 16'(dir_if.data_out), 16'(exp_dir));
            end
        end
        if (spl_if.data_out_valid) begin
            if (spl_q.size() == 0) begin
                checkOutput("spl_unexpected_resp", 16'(spl_if.data_out_valid), 16'h0);
            end else begin
                exp_spl = spl_q.pop_front();
                checkOutput("spl_rdata", 16'(spl_if.data_out), 16'(exp_spl));
            end
        end
        if (dir_if.split_ack) begin
            checkOutput("dir_split_ack", 16'(dir_if.split_ack), 16'h0);
        end
        if (spl_if.ack || spl_if.split_ack) begin
            checkOutput("spl_ack_excl", 16'(spl_if.ack & spl_if.split_ack), 16'h0);
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("reset_dir_status", 16'(status(0)), 16'(S_IDLE));
        checkOutput("reset_spl_status", 16'(status(1)), 16'(S_IDLE));
        checkOutput("reset_dir_data", 16'(dir_if.data_out), 16'h0000);
        checkOutput("reset_spl_data", 16'(spl_if.data_out), 16'h0000);
        rst_n = 1'b1;
        tick();

        $display("[TB] direct path");
        writeOp(0, 16'h0123, 8'hA5);
        directRead(16'h0123, 8'hA5);
        writeOp(0, 16'h07FF, 8'h5A);
        directRead(16'h07FF, 8'h5A);
        directRead(16'h0123, 8'hA5);

        $display("[TB] split path");
        writeOp(1, 16'h0040, 8'h3C);
        splitRead(16'h0040, 8'h3C, 0, 1'b0, 1'b0);
        splitRead(16'h0040, 8'h3C, 20, 1'b1, 1'b0);
        splitRead(16'h0040, 8'h3C, 0, 1'b0, 1'b0);

        $display("[TB] address truncation");
        writeOp(1, 16'hF801, 8'h11);
        splitRead(16'h0001, 8'h11, 3, 1'b0, 1'b0);

        $display("[TB] reset in REQ");
        splitRead(16'h0001, 8'h11, 0, 1'b0, 1'b1);
        splitRead(16'h0040, 8'h3C, 0, 1'b0, 1'b0);
        directRead(16'h07FF, 8'h5A);

        repeat (3) tick();
        checkOutput("sb_dir_drained", 16'(dir_q.size()), 16'h0);
        checkOutput("sb_spl_drained", 16'(spl_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
